// File: rtl/nios2_oci_trace_capture.sv
// Captures Nios II OCI data-compression-trace frames into a show-ahead FIFO
// and drains them over valid/ready, tracking dropped frames and end-of-test.
module nios2_oci_trace_capture #(
    parameter int DATA_W  = 30,
    parameter int COUNT_W = 4,
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int DROP_W  = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       arm,
    input  logic [DATA_W-1:0]          dct_buffer,
    input  logic [COUNT_W-1:0]         dct_count,
    input  logic                       test_ending,
    input  logic                       test_has_ended,
    output logic [DATA_W+COUNT_W-1:0]  out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ADDR_W:0]            fill_level,
    output logic                       overflow,
    output logic [DROP_W-1:0]          drop_count,
    output logic                       capturing,
    output logic                       test_done
);

    localparam int WORD_W = DATA_W + COUNT_W;
    localparam logic [ADDR_W:0]   FILL_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   FILL_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t state, state_next;

    logic [WORD_W-1:0] ram [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   fill, fill_next;

    logic wr_req, rd_en, wr_en, full, drop, flush, clear;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + DROP_W'(1);
    endfunction

    assign full   = (fill == FILL_FULL);
    assign wr_req = (state == CAPTURE) && (dct_count != '0);
    assign rd_en  = out_valid && out_ready;
    // A full FIFO still takes a write when the head is popped in the same cycle.
    assign wr_en  = wr_req && (!full || rd_en);
    assign drop   = wr_req && full && !rd_en;
    assign flush  = test_has_ended && (state != IDLE);
    assign clear  = (state == DONE) && arm && !test_has_ended;

    always_comb begin
        fill_next = fill;
        case ({wr_en, rd_en})
            2'b10:   fill_next = fill + FILL_ONE;
            2'b01:   fill_next = fill - FILL_ONE;
            default: fill_next = fill;
        endcase
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = DONE;
        end else begin
            case (state)
                IDLE:    if (arm)              state_next = CAPTURE;
                CAPTURE: if (test_ending)      state_next = DRAIN;
                DRAIN:   if (fill_next == '0)  state_next = DONE;
                DONE:    if (arm)              state_next = CAPTURE;
                default:                       state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill       <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            state <= state_next;
            if (flush || clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                fill   <= '0;
            end else begin
                if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
                if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
                fill <= fill_next;
            end
            if (clear) begin
                overflow   <= 1'b0;
                drop_count <= '0;
            end else if (drop && !flush) begin
                overflow   <= 1'b1;
                drop_count <= sat_inc(drop_count);
            end
        end
    end

    // Payload storage carries no reset; visibility is gated by the fill count.
    always_ff @(posedge clk) begin
        if (wr_en) ram[wr_ptr] <= {dct_count, dct_buffer};
    end

    assign out_valid  = (fill != '0);
    assign out_data   = out_valid ? ram[rd_ptr] : '0;
    assign fill_level = fill;
    assign capturing  = (state == CAPTURE);
    assign test_done  = (state == DONE);

endmodule

// File: tb/tb_nios2_oci_trace_capture.sv
// Directed bench for nios2_oci_trace_capture with a queue-based scoreboard
// checked by an independent monitor on every accepted head pop.
module tb_nios2_oci_trace_capture;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        arm = 1'b0;
    logic [29:0] dct_buffer = '0;
    logic [3:0]  dct_count = '0;
    logic        test_ending = 1'b0;
    logic        test_has_ended = 1'b0;
    logic [33:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  fill_level;
    logic        overflow;
    logic [7:0]  drop_count;
    logic        capturing;
    logic        test_done;

    int checks = 0;
    int failures = 0;
    logic [33:0] sb[$];

    always #5 clk = ~clk;

    nios2_oci_trace_capture #(
        .DATA_W(30), .COUNT_W(4), .DEPTH(16), .ADDR_W(4), .DROP_W(8)
    ) dut (
        .clk(clk), .reset_n(reset_n), .arm(arm),
        .dct_buffer(dct_buffer), .dct_count(dct_count),
        .test_ending(test_ending), .test_has_ended(test_has_ended),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .fill_level(fill_level), .overflow(overflow), .drop_count(drop_count),
        .capturing(capturing), .test_done(test_done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [3:0] c, input logic [29:0] d, input bit expect_out);
        dct_count  = c;
        dct_buffer = d;
        if (expect_out) sb.push_back({c, d});
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (reset_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pop actual=%0h expected=none", out_data);
                end else begin
                    check("pop_data", 64'(out_data), 64'(sb.pop_front()));
                end
            end
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_valid"}, 64'(out_valid), 0);
        check({name, "_data"}, 64'(out_data), 0);
        check({name, "_fill"}, 64'(fill_level), 0);
        check({name, "_ovf"}, 64'(overflow), 0);
        check({name, "_drop"}, 64'(drop_count), 0);
        check({name, "_capt"}, 64'(capturing), 0);
        check({name, "_done"}, 64'(test_done), 0);
    endtask

    initial begin
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) tick();
        check_all_zero("reset");
        reset_n = 1'b1;
        tick();

        // Basic capture of three frames, then ordered drain
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("arm_capturing", 64'(capturing), 1);
        for (int i = 1; i <= 3; i++) begin
            frame(4'd1, 30'(i), 1'b1);
            tick();
        end
        frame(4'd0, 30'h0, 1'b0);
        check("t1_fill", 64'(fill_level), 3);
        check("t1_valid", 64'(out_valid), 1);
        check("t1_head", 64'(out_data), 64'h0_4000_0001);
        out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0;
        check("t1_fill_after", 64'(fill_level), 0);
        check("t1_valid_after", 64'(out_valid), 0);

        // Overflow: 20 frames into 16 entries
        for (int i = 0; i < 20; i++) begin
            frame(4'((i % 15) + 1), 30'(100 + i), i < 16);
            tick();
        end
        frame(4'd0, 30'h0, 1'b0);
        check("t2_fill", 64'(fill_level), 16);
        check("t2_ovf", 64'(overflow), 1);
        check("t2_drop", 64'(drop_count), 4);

        // Full with simultaneous write and read, across pointer wrap
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            frame(4'hF, 30'(200 + i), 1'b1);
            tick();
            check("t3_fill_hold", 64'(fill_level), 16);
        end
        frame(4'd0, 30'h0, 1'b0);
        out_ready = 1'b0;
        check("t3_drop", 64'(drop_count), 4);
        out_ready = 1'b1;
        repeat (16) tick();
        out_ready = 1'b0;
        check("t3_drained", 64'(fill_level), 0);

        // test_ending with a frame in the same cycle, then drain to DONE
        for (int i = 0; i < 6; i++) begin
            frame(4'd2, 30'(300 + i), 1'b1);
            tick();
        end
        frame(4'd3, 30'd306, 1'b1);
        test_ending = 1'b1;
        tick();
        test_ending = 1'b0;
        frame(4'd1, 30'h3AA, 1'b0);
        out_ready = 1'b1;
        check("t4_not_capturing", 64'(capturing), 0);
        check("t4_fill", 64'(fill_level), 7);
        repeat (6) tick();
        check("t4_not_done", 64'(test_done), 0);
        check("t4_fill_one", 64'(fill_level), 1);
        tick();
        frame(4'd0, 30'h0, 1'b0);
        out_ready = 1'b0;
        check("t4_done", 64'(test_done), 1);
        check("t4_empty", 64'(out_valid), 0);
        check("t4_ovf_sticky", 64'(overflow), 1);

        // Re-arm from DONE clears sticky status
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("t5_rearm_capt", 64'(capturing), 1);
        check("t5_rearm_ovf", 64'(overflow), 0);
        check("t5_rearm_drop", 64'(drop_count), 0);

        // Abort with 10 frames buffered; abort wins over test_ending and arm
        for (int i = 0; i < 10; i++) begin
            frame(4'd1, 30'(500 + i), 1'b0);
            tick();
        end
        check("t5_fill10", 64'(fill_level), 10);
        frame(4'd1, 30'd999, 1'b0);
        test_has_ended = 1'b1;
        test_ending = 1'b1;
        arm = 1'b1;
        tick();
        test_has_ended = 1'b0;
        test_ending = 1'b0;
        arm = 1'b0;
        frame(4'd0, 30'h0, 1'b0);
        check("t5_abort_done", 64'(test_done), 1);
        check("t5_abort_valid", 64'(out_valid), 0);
        check("t5_abort_fill", 64'(fill_level), 0);
        check("t5_abort_data", 64'(out_data), 0);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("t5_arm_capt", 64'(capturing), 1);

        // Drop counter saturation
        for (int i = 0; i < 276; i++) begin
            frame(4'((i % 15) + 1), 30'(1000 + i), 1'b0);
            tick();
        end
        frame(4'd0, 30'h0, 1'b0);
        check("sat_drop", 64'(drop_count), 255);
        check("sat_ovf", 64'(overflow), 1);
        check("sat_fill", 64'(fill_level), 16);
        test_has_ended = 1'b1;
        tick();
        test_has_ended = 1'b0;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("sat_clear_drop", 64'(drop_count), 0);
        check("sat_clear_ovf", 64'(overflow), 0);

        // Asynchronous reset mid-capture with 5 frames buffered
        for (int i = 0; i < 5; i++) begin
            frame(4'd4, 30'(2000 + i), 1'b0);
            tick();
        end
        frame(4'd0, 30'h0, 1'b0);
        check("t6_fill5", 64'(fill_level), 5);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        tick();
        reset_n = 1'b1;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int i = 0; i < 4; i++) begin
            frame(4'd0, 30'h2AAAAAAA, 1'b0);
            tick();
        end
        check("t6_no_write_fill", 64'(fill_level), 0);
        check("t6_no_write_valid", 64'(out_valid), 0);
        check("t6_capt", 64'(capturing), 1);

        // Write into an empty FIFO while the consumer is ready
        out_ready = 1'b1;
        frame(4'd2, 30'h55, 1'b1);
        tick();
        frame(4'd0, 30'h0, 1'b0);
        check("empty_wr_fill", 64'(fill_level), 1);
        tick();
        out_ready = 1'b0;
        check("empty_wr_drained", 64'(fill_level), 0);

        repeat (2) tick();
        check("sb_empty", 64'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nios2_oci_trace_capture.md
Name: nios2_oci_trace_capture

Overview:
Parametrised successor to the OCI test-bench monitor. It captures data-compression-trace (DCT) frames from the Nios II OCI debug path into a show-ahead FIFO and drains them to a downstream consumer over a valid/ready handshake. It tracks overflow and end-of-test, so simulation benches and on-chip debug logic can read an ordered trace and a done indication. It sits beside the OCI block in the gameVisuals Qsys system and replaces the empty test-bench stub.

Parameters:
DATA_W, 30, width of dct_buffer payload
COUNT_W, 4, width of dct_count
DEPTH, 16, FIFO entries; must be a power of 2, minimum 2
ADDR_W, 4, log2(DEPTH)
DROP_W, 8, width of the saturating dropped-frame counter

Ports:
clk  input  1  single clock; all logic rising-edge
reset_n  input  1  asynchronous active-low reset
arm  input  1  one-cycle pulse; starts a capture session
dct_buffer  input  DATA_W  trace payload
dct_count  input  COUNT_W  valid-frame count; nonzero means a frame is present this cycle
test_ending  input  1  level/pulse; stops capture and begins drain
test_has_ended  input  1  pulse; aborts the session immediately
out_data  output  DATA_W+COUNT_W  {count, payload} at FIFO head
out_valid  output  1  head entry valid
out_ready  input  1  consumer accepts head
fill_level  output  ADDR_W+1  entries stored, 0..DEPTH
overflow  output  1  sticky; a frame was dropped
drop_count  output  DROP_W  dropped frames, saturating at all-ones
capturing  output  1  state==CAPTURE
test_done  output  1  state==DONE

Behaviour:
- Reset (reset_n low, async): state=IDLE; FIFO empty; out_valid=0; out_data=0; fill_level=0; overflow=0; drop_count=0; capturing=0; test_done=0.
- States: IDLE, CAPTURE, DRAIN, DONE; state registered. capturing and test_done are decoded from the state register.
- IDLE -> CAPTURE on arm.
- DONE -> CAPTURE on arm. On that transition: overflow, drop_count and the FIFO are cleared.
- CAPTURE -> DRAIN on test_ending=1. A frame presented in the same cycle as test_ending is still written.
- DRAIN -> DONE in the cycle the FIFO becomes empty. The check uses the post-update count, so the last accepted read moves the state to DONE at that edge.
- Any state except IDLE -> DONE on test_has_ended. The FIFO is flushed at the same edge, so out_valid=0 the next cycle. test_has_ended takes priority over test_ending and arm.
- arm in CAPTURE or DRAIN is ignored. Writes are accepted only in CAPTURE.
- Write condition: state==CAPTURE and dct_count!=0. Stored word = {dct_count, dct_buffer}.
- Read condition: out_valid and out_ready. The FIFO is show-ahead: out_data reflects the head combinationally from the registered RAM/pointers.
- Latency: a write at edge N gives out_valid=1 after edge N when the FIFO was empty. A head pop at edge N exposes the next entry after edge N.
- Full (fill_level==DEPTH) with a write and no read: the frame is dropped. overflow sets to 1 (sticky); drop_count increments and saturates at 2^DROP_W-1.
- Full with a simultaneous read and write: both are accepted; fill_level is unchanged; no drop.
- Empty with a simultaneous write and read: no read is possible because out_valid=0; the write is accepted.
- Pointers are ADDR_W bits wide and wrap modulo DEPTH. fill_level is tracked separately with ADDR_W+1 bits, giving exact full/empty.
- out_data is don't-care when out_valid=0. It is driven 0 after reset and after a flush.
- Reading is permitted in CAPTURE, DRAIN and DONE; the FIFO is empty in DONE except after a DRAIN completion, where it is already empty.
- Reset asserted mid-operation discards all state immediately; no partial outputs.

Test Plan:
- Reset then arm, present 3 frames (dct_count=1, dct_buffer=0x1, 0x2, 0x3) with out_ready=0 -> fill_level=3, out_valid=1, out_data={4'd1,30'h1}; then out_ready=1 for 3 cycles -> frames 1,2,3 in order, fill_level=0.
- Arm, 20 frames with out_ready=0 at DEPTH=16 -> fill_level=16, overflow=1, drop_count=4; the first 16 frames are read back intact.
- Full FIFO with a simultaneous write and read for 5 cycles -> fill_level stays 16, drop_count unchanged, order preserved across pointer wrap.
- 6 frames buffered, pulse test_ending, out_ready=1 -> capturing=0 next cycle; frames presented after test_ending are ignored; test_done=1 at the edge of the 6th pop.
- 10 frames buffered, pulse test_has_ended -> next cycle test_done=1, out_valid=0, fill_level=0; a following arm clears overflow/drop_count and capturing=1.
- Deassert reset_n mid-capture with 5 frames buffered -> all outputs 0 immediately; arm with dct_count=0 for 4 cycles -> no writes, fill_level=0.
